// File: rtl/find_max_pkg.sv
// Shared types and defaults for the find-max frame sequencer.
package find_max_pkg;

  localparam int DEPTH_DEF   = 128;
  localparam int ADDR_W_DEF  = 7;
  localparam int DATA_W_DEF  = 8;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SETTLE,
    ST_HAND,
    ST_WAIT_FIN,
    ST_LATCH
  } state_e;

endpackage

// File: rtl/find_max_frame_ctrl_frame_write_port.sv
// Port-A writer: owns the write pointer, the registered wea/addra/dina and the last-sample flag.
module frame_write_port
  import find_max_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_data_i,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [DATA_W-1:0] dina_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              accept;

  assign accept = en_i & sample_valid_i;
  assign last_o = accept & (wr_ptr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    // NOTE: every _d gets a default first so no latch is inferred on idle paths.
    wr_ptr_d = wr_ptr_q;
    wea_d    = 1'b0;
    addra_d  = addra_q;
    dina_d   = dina_q;
    if (clr_i) begin
      wr_ptr_d = '0;
    end else if (accept) begin
      wea_d    = 1'b1;
      addra_d  = wr_ptr_q;
      dina_d   = sample_data_i;
      wr_ptr_d = last_o ? '0 : wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    if (rst_i) begin
      wr_ptr_q <= '0;
      wea_q    <= 1'b0;
      addra_q  <= '0;
      dina_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      wea_q    <= wea_d;
      addra_q  <= addra_d;
      dina_q   <= dina_d;
    end
  end

  assign wea_o   = wea_q;
  assign addra_o = addra_q;
  assign dina_o  = dina_q;

endmodule

// File: rtl/find_max_frame_ctrl.sv
// Frame sequencer: fills the sample RAM, hands it to the find-max reader, latches the result.
// Optional WAIT_FIN abort with timeout_err is built when FIND_MAX_FRAME_CTRL_TIMEOUT_EN is defined.
module find_max_frame_ctrl
  import find_max_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   sample_valid,
  input  logic [DATA_W-1:0]      sample_data,
  output logic                   wea,
  output logic [ADDR_W-1:0]      addra,
  output logic [DATA_W-1:0]      dina,
  output logic                   readyb,
  input  logic                   finishb,
  input  logic [DATA_W-1:0]      max_data_in,
  input  logic [ADDR_W-1:0]      max_addr_in,
  input  logic                   no_max_in,
  output logic [DATA_W-1:0]      result_data,
  output logic [ADDR_W-1:0]      result_addr,
  output logic                   result_none,
  output logic                   result_valid,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   drop_flag
`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
  , output logic                 timeout_err
`endif
);

  state_e                   state_q, state_d;
  logic                     readyb_q, readyb_d;
  logic                     fin_q;
  logic [DATA_W-1:0]        res_data_q, res_data_d;
  logic [ADDR_W-1:0]        res_addr_q, res_addr_d;
  logic                     res_none_q, res_none_d;
  logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                     drop_q, drop_d;
  logic                     last_sample;
  logic                     fin_rise;

`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;
`endif

  frame_write_port #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_write_port (
    .clk_i          (clk_in),
    .rst_i          (rst),
    .en_i           (state_q == ST_FILL),
    .clr_i          (state_q == ST_IDLE),
    .sample_valid_i (sample_valid),
    .sample_data_i  (sample_data),
    .wea_o          (wea),
    .addra_o        (addra),
    .dina_o         (dina),
    .last_o         (last_sample)
  );

  // A finishb that is already high on entry to WAIT_FIN never produces a rise here.
  assign fin_rise = finishb & ~fin_q;

  always_comb begin
    state_d     = state_q;
    readyb_d    = readyb_q;
    res_data_d  = res_data_q;
    res_addr_d  = res_addr_q;
    res_none_d  = res_none_q;
    frame_cnt_d = frame_cnt_q;
    drop_d      = drop_q | (sample_valid & (state_q != ST_FILL));
`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
    to_cnt_d    = (state_q == ST_WAIT_FIN) ? to_cnt_q + 1'b1 : '0;
    to_err_d    = to_err_q;
`endif
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_FILL;
      ST_FILL:   if (last_sample) state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_HAND;
      ST_HAND: begin
        readyb_d = 1'b1;
        state_d  = ST_WAIT_FIN;
      end
      ST_WAIT_FIN: begin
        if (fin_rise) begin
          res_data_d = max_data_in;
          res_addr_d = max_addr_in;
          res_none_d = no_max_in;
          state_d    = ST_LATCH;
        end
`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          res_data_d = '0;
          res_addr_d = '0;
          res_none_d = 1'b1;
          to_err_d   = 1'b1;
          state_d    = ST_LATCH;
        end
`endif
      end
      ST_LATCH: begin
        readyb_d    = 1'b0;
        frame_cnt_d = frame_cnt_q + 1'b1;
        state_d     = continuous ? ST_FILL : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      readyb_q    <= 1'b0;
      fin_q       <= 1'b0;
      res_data_q  <= '0;
      res_addr_q  <= '0;
      res_none_q  <= 1'b0;
      frame_cnt_q <= '0;
      drop_q      <= 1'b0;
`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
      to_cnt_q    <= '0;
      to_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      readyb_q    <= readyb_d;
      fin_q       <= finishb;
      res_data_q  <= res_data_d;
      res_addr_q  <= res_addr_d;
      res_none_q  <= res_none_d;
      frame_cnt_q <= frame_cnt_d;
      drop_q      <= drop_d;
`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      to_err_q    <= to_err_d;
`endif
    end
  end

  assign readyb       = readyb_q;
  assign result_data  = res_data_q;
  assign result_addr  = res_addr_q;
  assign result_none  = res_none_q;
  assign result_valid = (state_q == ST_LATCH);
  assign busy         = (state_q != ST_IDLE);
  assign frame_count  = frame_cnt_q;
  assign drop_flag    = drop_q;
`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
  assign timeout_err  = to_err_q;
`endif

endmodule

// File: tb/tb_find_max_frame_ctrl.sv
// Scoreboard bench for find_max_frame_ctrl; writes and results are checked by a negedge monitor.
module tb_find_max_frame_ctrl;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic              none;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } res_t;

  logic              clk_in = 1'b0;
  logic              rst, start, continuous, sample_valid, finishb, no_max_in;
  logic [DATA_W-1:0] sample_data, max_data_in;
  logic [ADDR_W-1:0] max_addr_in;
  logic              wea, readyb, result_none, result_valid, busy, drop_flag;
  logic [ADDR_W-1:0] addra, result_addr;
  logic [DATA_W-1:0] dina, result_data;
  logic [15:0]       frame_count;
`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
  logic              timeout_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_frames = 0;

  wr_t  wr_q[$];
  res_t res_q[$];

  // monitor bookkeeping
  int   last_wea_cyc = 0, rise_cyc = 0, rise_gap = 0, rise_cnt = 0;
  int   rv_cnt = 0, rv_cyc = 0, low_run = 0, min_low = 1000;
  logic rb_prev = 1'b0;
  wr_t  w_pop;
  res_t r_pop;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  find_max_frame_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
    , .TIMEOUT (16)
`endif
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .start        (start),
    .continuous   (continuous),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .wea          (wea),
    .addra        (addra),
    .dina         (dina),
    .readyb       (readyb),
    .finishb      (finishb),
    .max_data_in  (max_data_in),
    .max_addr_in  (max_addr_in),
    .no_max_in    (no_max_in),
    .result_data  (result_data),
    .result_addr  (result_addr),
    .result_none  (result_none),
    .result_valid (result_valid),
    .busy         (busy),
    .frame_count  (frame_count),
    .drop_flag    (drop_flag)
`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
    , .timeout_err (timeout_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int f, input int i);
    if (f == 0) return (i == 77) ? 8'hF0 : DATA_W'(i);
    return DATA_W'((i * 37 + f * 11) & 255);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_wea"},          32'(wea),          32'd0);
    check({tag, "_addra"},        32'(addra),        32'd0);
    check({tag, "_dina"},         32'(dina),         32'd0);
    check({tag, "_readyb"},       32'(readyb),       32'd0);
    check({tag, "_result_data"},  32'(result_data),  32'd0);
    check({tag, "_result_addr"},  32'(result_addr),  32'd0);
    check({tag, "_result_none"},  32'(result_none),  32'd0);
    check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_busy"},         32'(busy),         32'd0);
    check({tag, "_frame_count"},  32'(frame_count),  32'd0);
    check({tag, "_drop_flag"},    32'(drop_flag),    32'd0);
`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
    check({tag, "_timeout_err"},  32'(timeout_err),  32'd0);
`endif
  endtask

  task automatic wait_readyb(input logic lvl, input string name);
    int n = 0;
    @(negedge clk_in);
    while (readyb !== lvl && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    check(name, 32'(readyb), 32'(lvl));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk_in);
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  // Streams n samples of pattern f, with a one-cycle gap before every 16th sample.
  task automatic fill_frame(input int f, input int n, input logic do_start);
    if (do_start) begin
      @(posedge clk_in); #1 start = 1'b1;
      @(posedge clk_in); #1 start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      if (i % 16 == 15) begin
        @(posedge clk_in); #1 sample_valid = 1'b0;
      end
      @(posedge clk_in); #1;
      sample_valid = 1'b1;
      sample_data  = pat(f, i);
      wr_q.push_back('{addr: ADDR_W'(i), data: pat(f, i)});
    end
    @(posedge clk_in); #1 sample_valid = 1'b0;
  endtask

  // Reader model: waits for readyb, reports after a short latency, releases after readyb drops.
  task automatic reader(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                        input logic none, input logic cont);
    wait_readyb(1'b1, "reader_readyb_up");
    repeat (3) @(posedge clk_in);
    #1;
    max_data_in = d;
    max_addr_in = a;
    no_max_in   = none;
    continuous  = cont;
    finishb     = 1'b1;
    res_q.push_back('{none: none, addr: a, data: d});
    exp_frames++;
    wait_readyb(1'b0, "reader_readyb_down");
    @(posedge clk_in); #1 finishb = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk_in);
      if (wea) begin
        if (wr_q.size() == 0) check("wea_unexpected", 32'(wea), 32'd0);
        else begin
          w_pop = wr_q.pop_front();
          check("addra", 32'(addra), 32'(w_pop.addr));
          check("dina",  32'(dina),  32'(w_pop.data));
        end
        last_wea_cyc = cyc;
      end
      if (result_valid) begin
        if (res_q.size() == 0) check("result_valid_unexpected", 32'(result_valid), 32'd0);
        else begin
          r_pop = res_q.pop_front();
          check("result_data", 32'(result_data), 32'(r_pop.data));
          check("result_addr", 32'(result_addr), 32'(r_pop.addr));
          check("result_none", 32'(result_none), 32'(r_pop.none));
        end
        rv_cnt++;
        rv_cyc = cyc;
      end
      if (readyb && !rb_prev) begin
        if (rise_cnt > 0 && low_run < min_low) min_low = low_run;
        rise_cnt++;
        rise_cyc = cyc;
        rise_gap = cyc - last_wea_cyc;
      end
      low_run = readyb ? 0 : low_run + 1;
      rb_prev = readyb;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rv_before;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; sample_valid = 1'b0; sample_data = '0;
    finishb = 1'b0; max_data_in = '0; max_addr_in = '0; no_max_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_all_zero("reset");
    @(posedge clk_in); #1 rst = 1'b0;

    // Single shot with a drop injected during WAIT_FIN.
    fill_frame(0, DEPTH, 1'b1);
    wait_readyb(1'b1, "ss_readyb_up");
    check("ss_readyb_gap",  32'(rise_gap),  32'd2);
    check("ss_drop_before", 32'(drop_flag), 32'd0);
    check("ss_busy",        32'(busy),      32'd1);
    @(posedge clk_in); #1 sample_valid = 1'b1; sample_data = 8'hAA;
    @(posedge clk_in); #1 sample_valid = 1'b0;
    @(negedge clk_in);
    check("drop_set",     32'(drop_flag), 32'd1);
    check("drop_no_wea",  32'(wea),       32'd0);
    reader(8'hF0, 7'd77, 1'b0, 1'b0);
    wait_idle("ss_idle");
    check("ss_frame_count", 32'(frame_count), 32'(exp_frames));
    check("ss_result_hold", 32'(result_data), 32'hF0);
    check("ss_readyb_low",  32'(readyb),      32'd0);

    // Continuous: three frames, last one with no_max and boundary addresses.
    rise_cnt = 0; rv_cnt = 0; min_low = 1000;
    continuous = 1'b1;
    fill_frame(1, DEPTH, 1'b1);
    reader(8'h55, 7'd0, 1'b0, 1'b1);
    fill_frame(2, DEPTH, 1'b0);
    reader(8'hFF, 7'd127, 1'b0, 1'b1);
    fill_frame(3, DEPTH, 1'b0);
    reader(8'h00, 7'd0, 1'b1, 1'b0);
    wait_idle("cont_idle");
    check("cont_frame_count",  32'(frame_count), 32'(exp_frames));
    check("cont_rv_pulses",    32'(rv_cnt),      32'd3);
    check("cont_readyb_rises", 32'(rise_cnt),    32'd3);
    check("cont_readyb_lowmin", 32'(min_low >= 2), 32'd1);
    check("drop_sticky",       32'(drop_flag),   32'd1);

    // Mid-frame reset after 50 samples, then a fresh frame from address 0.
    fill_frame(5, 50, 1'b1);
    rst = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    check_all_zero("midrst");
    @(posedge clk_in); #1 rst = 1'b0;
    exp_frames = 0;
    fill_frame(6, DEPTH, 1'b1);
    reader(8'h80, 7'd5, 1'b0, 1'b0);
    wait_idle("fresh_idle");
    check("fresh_frame_count", 32'(frame_count), 32'(exp_frames));

    // Stale finishb: high before HAND, must fall and rise again.
    finishb = 1'b1;
    fill_frame(7, DEPTH, 1'b1);
    wait_readyb(1'b1, "stale_readyb_up");
    rv_before = rv_cnt;
    repeat (6) @(negedge clk_in);
    check("stale_busy",        32'(busy),        32'd1);
    check("stale_no_capture",  32'(rv_cnt),      32'(rv_before));
    check("stale_result_hold", 32'(result_data), 32'h80);
    @(posedge clk_in); #1 finishb = 1'b0;
    repeat (2) @(posedge clk_in);
    reader(8'h12, 7'd100, 1'b0, 1'b0);
    wait_idle("stale_idle");
    check("stale_frame_count", 32'(frame_count), 32'(exp_frames));

`ifdef FIND_MAX_FRAME_CTRL_TIMEOUT_EN
    // No finishb at all: abort after 16 cycles in WAIT_FIN.
    fill_frame(8, DEPTH, 1'b1);
    wait_readyb(1'b1, "to_readyb_up");
    res_q.push_back('{none: 1'b1, addr: '0, data: '0});
    exp_frames++;
    wait_idle("to_idle");
    check("to_latency",     32'(rv_cyc - rise_cyc), 32'd16);
    check("to_err",         32'(timeout_err),       32'd1);
    check("to_frame_count", 32'(frame_count),       32'(exp_frames));
`endif

    repeat (4) @(negedge clk_in);
    check("wr_q_drained",  32'(wr_q.size()),  32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
